// File: rtl/audio_pkg.sv
// Shared definitions for the stereo gain stage: sample geometry, channel
// packing within a 32-bit frame, and the FSM state encoding.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;
  localparam int NUM_CH   = 2;
  localparam int CH_R_LSB = 0;
  localparam int CH_L_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Channel index 0 is right (low half), 1 is left (high half).
  function automatic int ch_lsb(input int ch);
    return (ch == 0) ? CH_R_LSB : CH_L_LSB;
  endfunction

endpackage

// File: rtl/audio_gain_stage_if.sv
// FIFO-side bus of the gain stage: FWFT ADC FIFO read port and DAC FIFO write port.
interface audio_gain_stage_if;
  import audio_pkg::*;

  logic [NUM_CH*SAMPLE_W-1:0] adc_data_out;
  logic                       adc_fifo_empty;
  logic                       adc_data_rd;
  logic [NUM_CH*SAMPLE_W-1:0] dac_data_in;
  logic                       dac_data_wr;
  logic                       dac_fifo_full;

  modport master (
    input  adc_data_out,
    input  adc_fifo_empty,
    input  dac_fifo_full,
    output adc_data_rd,
    output dac_data_in,
    output dac_data_wr
  );

  modport slave (
    output adc_data_out,
    output adc_fifo_empty,
    output dac_fifo_full,
    input  adc_data_rd,
    input  dac_data_in,
    input  dac_data_wr
  );
endinterface

// File: rtl/audio_gain_sat.sv
// One channel: signed sample times unsigned fixed-point gain, floor shift,
// saturate to the signed sample range and flag when saturation occurred.
module audio_gain_sat
  import audio_pkg::*;
#(
  parameter int GAIN_FRAC = 4
) (
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [SAMPLE_W-1:0] result,
  output logic                       clip
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0]         product;
  logic signed [PROD_W-1:0]         shifted;
  logic        [PROD_W-SAMPLE_W:0]  top_bits;

  always_comb begin
    product  = PROD_W'(sample) * $signed(PROD_W'({1'b0, gain}));
    shifted  = product >>> GAIN_FRAC;
    // Fits in SAMPLE_W only if every bit above the new sign bit matches it.
    top_bits = shifted[PROD_W-1:SAMPLE_W-1];
    clip     = !((&top_bits) || !(|top_bits));
    if (clip) begin
      result = shifted[PROD_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                 : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      result = shifted[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/audio_gain_stage.sv
// Stereo gain stage: pops a frame from the ADC FIFO, applies per-channel gain
// with saturation (or bypass/mute), and pushes the result to the DAC FIFO.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int GAIN_FRAC = 4,
  parameter int CLIP_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 bypass,
  input  logic                 mute,
  input  logic [GAIN_W-1:0]    gain_l,
  input  logic [GAIN_W-1:0]    gain_r,
  input  logic                 clip_clr,
  output logic [CLIP_W-1:0]    clip_cnt,
  output logic                 busy,
  audio_gain_stage_if.master   fifo
);

  localparam int FRAME_W = NUM_CH * SAMPLE_W;

  state_t                        state_reg, state_next;
  logic [FRAME_W-1:0]            sample_reg;
  logic [FRAME_W-1:0]            sat_data;
  logic [FRAME_W-1:0]            out_reg, out_next;
  logic [NUM_CH-1:0][GAIN_W-1:0] gain_reg;
  logic                          bypass_reg, mute_reg;
  logic [NUM_CH-1:0]             clip_ch;
  logic                          clip_event;
  logic                          fetch, write;
  logic [CLIP_W-1:0]             clip_cnt_reg, clip_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      audio_gain_sat #(
        .GAIN_FRAC (GAIN_FRAC)
      ) u_sat (
        .sample (sample_reg[ch_lsb(gi) +: SAMPLE_W]),
        .gain   (gain_reg[gi]),
        .result (sat_data[ch_lsb(gi) +: SAMPLE_W]),
        .clip   (clip_ch[gi])
      );
    end
  endgenerate

  // Fetch is gated by rst so no pop strobe can appear while held in reset.
  always_comb begin
    state_next = state_reg;
    fetch      = 1'b0;
    write      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rst && enable && !fifo.adc_fifo_empty) begin
          fetch      = 1'b1;
          state_next = CALC;
        end
      end
      CALC: state_next = WRITE;
      WRITE: begin
        if (!fifo.dac_fifo_full) begin
          write      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_reg <= '0;
      gain_reg   <= '0;
      bypass_reg <= 1'b0;
      mute_reg   <= 1'b0;
    end else if (fetch) begin
      sample_reg <= fifo.adc_data_out;
      gain_reg   <= {gain_l, gain_r};
      bypass_reg <= bypass;
      mute_reg   <= mute;
    end
  end

  always_comb begin
    out_next = out_reg;
    if (state_reg == CALC) begin
      if (mute_reg) begin
        out_next = '0;
      end else if (bypass_reg) begin
        out_next = sample_reg;
      end else begin
        out_next = sat_data;
      end
    end
  end

  assign clip_event = (state_reg == CALC) && !mute_reg && !bypass_reg && (|clip_ch);

  always_comb begin
    clip_cnt_next = clip_cnt_reg;
    if (clip_clr) begin
      clip_cnt_next = '0;
    end else if (clip_event && !(&clip_cnt_reg)) begin
      clip_cnt_next = clip_cnt_reg + CLIP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg      <= '0;
      clip_cnt_reg <= '0;
    end else begin
      out_reg      <= out_next;
      clip_cnt_reg <= clip_cnt_next;
    end
  end

  assign fifo.adc_data_rd = fetch;
  assign fifo.dac_data_wr = write;
  assign fifo.dac_data_in = out_reg;
  assign busy             = (state_reg != IDLE);
  assign clip_cnt         = clip_cnt_reg;

endmodule

// File: tb/tb_audio_gain_stage.sv
// Scoreboard bench for audio_gain_stage: directed frames with hand-computed
// results, FIFO models on both sides, and a monitor checking every write.
module tb_audio_gain_stage;
  import audio_pkg::*;

  localparam int CLIP_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              bypass = 1'b0;
  logic              mute = 1'b0;
  logic              clip_clr = 1'b0;
  logic [7:0]        gain_l = 8'h10;
  logic [7:0]        gain_r = 8'h10;
  logic [CLIP_W-1:0] clip_cnt;
  logic              busy;

  audio_gain_stage_if fifo ();

  audio_gain_stage #(
    .GAIN_FRAC (4),
    .CLIP_W    (CLIP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .bypass   (bypass),
    .mute     (mute),
    .gain_l   (gain_l),
    .gain_r   (gain_r),
    .clip_clr (clip_clr),
    .clip_cnt (clip_cnt),
    .busy     (busy),
    .fifo     (fifo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       data;
    logic [CLIP_W-1:0] clip;
    int                lat;
    string             name;
  } exp_t;

  exp_t              sb[$];
  logic [31:0]       adc_q[$];
  int                rd_cycles[$];
  int                total = 0;
  int                bad = 0;
  int                cycle = 0;
  int                rd_count = 0;
  int                wr_count = 0;
  logic [CLIP_W-1:0] exp_clip = '0;

  task automatic refresh_adc();
    fifo.adc_fifo_empty = (adc_q.size() == 0);
    fifo.adc_data_out   = (adc_q.size() != 0) ? adc_q[0] : 32'h0;
  endtask

  // Monitor: samples mid-cycle after inputs settle, pops ADC model after the edge.
  initial begin : monitor
    logic        rd_s, wr_s;
    logic [31:0] prev_data;
    int          stall;
    exp_t        e;
    int          rc;
    stall = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      cycle++;
      rd_s = fifo.adc_data_rd;
      wr_s = fifo.dac_data_wr;
      if (!rst) begin
        total++;
        if ({rd_s, wr_s, fifo.dac_data_in, clip_cnt, busy} !== '0) begin
          bad++;
          $display("FAIL reset_state: rd=%b wr=%b data=%h clip=%0d busy=%b required all zero",
                   rd_s, wr_s, fifo.dac_data_in, clip_cnt, busy);
        end
        rd_cycles.delete();
        stall = 0;
      end else begin
        total++;
        if (rd_s && (fifo.adc_fifo_empty || busy)) begin
          bad++;
          $display("FAIL rd_protocol: rd=1 empty=%b busy=%b required rd=0",
                   fifo.adc_fifo_empty, busy);
        end
        total++;
        if (wr_s && fifo.dac_fifo_full) begin
          bad++;
          $display("FAIL wr_protocol: wr=1 while full, required wr=0");
        end
        if (fifo.dac_fifo_full && busy) begin
          stall++;
          if (stall >= 3) begin
            total++;
            if (fifo.dac_data_in !== prev_data) begin
              bad++;
              $display("FAIL stall_hold: data=%h required=%h", fifo.dac_data_in, prev_data);
            end
          end
        end else begin
          stall = 0;
        end
        if (rd_s) begin
          rd_count++;
          rd_cycles.push_back(cycle);
        end
        if (wr_s) begin
          wr_count++;
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: data=%h required no write", fifo.dac_data_in);
          end else begin
            e  = sb.pop_front();
            rc = (rd_cycles.size() != 0) ? rd_cycles.pop_front() : -1000;
            if (fifo.dac_data_in !== e.data || clip_cnt !== e.clip || (cycle - rc) != e.lat) begin
              bad++;
              $display("FAIL %s: data=%h clip=%0d lat=%0d required data=%h clip=%0d lat=%0d",
                       e.name, fifo.dac_data_in, clip_cnt, cycle - rc, e.data, e.clip, e.lat);
            end else begin
              $display("write %s: data=%h clip=%0d lat=%0d ok", e.name, fifo.dac_data_in,
                       clip_cnt, cycle - rc);
            end
          end
        end
      end
      prev_data = fifo.dac_data_in;
      @(posedge clk);
      #1;
      if (rst && rd_s && adc_q.size() != 0) begin
        void'(adc_q.pop_front());
        refresh_adc();
      end
    end
  end

  task automatic push_frame(input logic [31:0] s, input logic [7:0] gl, input logic [7:0] gr,
                            input logic byp, input logic mu);
    @(negedge clk);
    gain_l = gl;
    gain_r = gr;
    bypass = byp;
    mute   = mu;
    adc_q.push_back(s);
    refresh_adc();
  endtask

  task automatic send(input logic [31:0] s, input logic [7:0] gl, input logic [7:0] gr,
                      input logic byp, input logic mu, input logic [31:0] exp_d,
                      input logic clipped, input int lat, input string name);
    exp_t e;
    if (clip_clr) exp_clip = '0;
    else if (clipped && !(&exp_clip)) exp_clip = exp_clip + 1'b1;
    e.data = exp_d;
    e.clip = exp_clip;
    e.lat  = lat;
    e.name = name;
    sb.push_back(e);
    push_frame(s, gl, gr, byp, mu);
  endtask

  task automatic wait_wr(input int target, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wr_count < target) begin
      bad++;
      $display("FAIL %s_timeout: writes=%0d required=%0d", name, wr_count, target);
    end
  endtask

  task automatic run(input logic [31:0] s, input logic [7:0] gl, input logic [7:0] gr,
                     input logic byp, input logic mu, input logic [31:0] exp_d,
                     input logic clipped, input string name);
    int tgt;
    tgt = wr_count + 1;
    send(s, gl, gr, byp, mu, exp_d, clipped, 2, name);
    wait_wr(tgt, name);
  endtask

  initial begin : stimulus
    int base, n, tgt;
    fifo.dac_fifo_full = 1'b0;
    refresh_adc();
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;

    run(32'h1000_F000, 8'h20, 8'h20, 1'b0, 1'b0, 32'h2000_E000, 1'b0, "gain2x");
    run(32'h7FFF_8000, 8'hFF, 8'h20, 1'b0, 1'b0, 32'h7FFF_8000, 1'b1, "sat_both");
    run(32'h1234_5678, 8'h20, 8'h20, 1'b1, 1'b1, 32'h0000_0000, 1'b0, "mute_over_bypass");
    run(32'h7FFF_8000, 8'hFF, 8'hFF, 1'b1, 1'b0, 32'h7FFF_8000, 1'b0, "bypass_no_count");
    run(32'h8000_7FFF, 8'h10, 8'h10, 1'b0, 1'b0, 32'h8000_7FFF, 1'b0, "unity_extremes");
    run(32'h0003_FFFD, 8'h08, 8'h08, 1'b0, 1'b0, 32'h0001_FFFE, 1'b0, "half_floor");
    run(32'h1234_8000, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "zero_gain");
    run(32'h5556_0001, 8'h18, 8'h10, 1'b0, 1'b0, 32'h7FFF_0001, 1'b1, "left_just_over");

    @(negedge clk);
    clip_clr = 1'b1;
    run(32'h5555_AAAA, 8'h18, 8'h18, 1'b0, 1'b0, 32'h7FFF_8000, 1'b1, "clr_wins");
    clip_clr = 1'b0;
    run(32'h5555_AAAA, 8'h18, 8'h18, 1'b0, 1'b0, 32'h7FFF_8000, 1'b1, "after_clr");

    // DAC stall: full for the 10 WRITE cycles, second frame queued meanwhile.
    @(negedge clk);
    fifo.dac_fifo_full = 1'b1;
    tgt = wr_count + 2;
    send(32'h1000_F000, 8'h20, 8'h20, 1'b0, 1'b0, 32'h2000_E000, 1'b0, 12, "stall_first");
    repeat (5) @(negedge clk);
    send(32'h0102_0304, 8'h10, 8'h10, 1'b0, 1'b0, 32'h0102_0304, 1'b0, 2, "stall_second");
    repeat (6) @(negedge clk);
    fifo.dac_fifo_full = 1'b0;
    wait_wr(tgt, "stall");

    // Enable dropped after the third fetch of eight queued frames.
    @(negedge clk);
    enable = 1'b0;
    gain_l = 8'h10;
    gain_r = 8'h10;
    for (int i = 1; i <= 8; i++) begin
      adc_q.push_back(32'h0001_0001 * i);
      if (i <= 3) sb.push_back('{32'h0001_0001 * i, exp_clip, 2, "enable_drop"});
    end
    refresh_adc();
    base = rd_count;
    tgt  = wr_count + 3;
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (rd_count < base + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    total++;
    if (rd_count < base + 3) begin
      bad++;
      $display("FAIL enable_fetch_timeout: fetches=%0d required=%0d", rd_count - base, 3);
    end
    wait_wr(tgt, "enable_drop");
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0 || adc_q.size() != 5 || wr_count != tgt) begin
      bad++;
      $display("FAIL enable_stop: busy=%b left=%0d writes=%0d required busy=0 left=5 writes=%0d",
               busy, adc_q.size(), wr_count, tgt);
    end
    adc_q.delete();
    refresh_adc();
    enable = 1'b1;

    // Reset during CALC discards the in-flight frame.
    push_frame(32'h1000_1000, 8'h20, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_clip = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    run(32'h1000_F000, 8'h20, 8'h20, 1'b0, 1'b0, 32'h2000_E000, 1'b0, "after_reset");

    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_gain_stage.md
AUDIO_GAIN_STAGE -- requirements
Module: audio_gain_stage

Interface
REQ-001 Parameter GAIN_FRAC, default 4, SHALL set the number of fractional bits in the unsigned gain words (Q4.4, so 8'h10 is unity).
REQ-002 Parameter CLIP_W, default 16, SHALL set the width of the clip counter.
REQ-003 Port clk  input  1  SHALL be the single system clock.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port enable  input  1  SHALL permit new sample fetches when high.
REQ-006 Port bypass  input  1  SHALL pass samples through with unity gain and no saturation counting.
REQ-007 Port mute  input  1  SHALL force the output sample to 0.
REQ-008 Port gain_l  input  8  SHALL be the left-channel gain, unsigned Q(8-GAIN_FRAC).GAIN_FRAC.
REQ-009 Port gain_r  input  8  SHALL be the right-channel gain, in the same format.
REQ-010 Port adc_data_out  input  32  SHALL be the FWFT ADC FIFO head, {left[31:16], right[15:0]}, each signed 16-bit.
REQ-011 Port adc_fifo_empty  input  1  SHALL be the ADC FIFO empty flag.
REQ-012 Port adc_data_rd  output  1  SHALL be the ADC FIFO pop strobe.
REQ-013 Port dac_data_in  output  32  SHALL be the processed sample, in the same packing.
REQ-014 Port dac_data_wr  output  1  SHALL be the DAC FIFO push strobe.
REQ-015 Port dac_fifo_full  input  1  SHALL be the DAC FIFO full flag.
REQ-016 Port clip_clr  input  1  SHALL clear clip_cnt synchronously.
REQ-017 Port clip_cnt  output  CLIP_W  SHALL count samples in which at least one channel saturated.
REQ-018 Port busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-019 The FSM SHALL use states IDLE, CALC and WRITE.
REQ-020 In IDLE with enable=1 and adc_fifo_empty=0, adc_data_rd SHALL pulse for exactly one cycle, adc_data_out, gain_l, gain_r, bypass and mute SHALL be captured in that same cycle, and the FSM SHALL move to CALC.
REQ-021 In CALC, each channel SHALL compute s16 x {1'b0, gain} as a signed 25-bit product, arithmetic-shift it right by GAIN_FRAC (floor), saturate it to [-32768, 32767], register the result, and the FSM SHALL move to WRITE.
REQ-022 With bypass captured high, CALC SHALL output the input sample unchanged.
REQ-023 With mute captured high, CALC SHALL output 32'h0; mute SHALL take priority over bypass.
REQ-024 In WRITE with dac_fifo_full=0, dac_data_wr SHALL pulse for one cycle with dac_data_in valid in that cycle, and the FSM SHALL return to IDLE.
REQ-025 In WRITE with dac_fifo_full=1, the FSM SHALL hold dac_data_in stable and keep dac_data_wr at 0.
REQ-026 Minimum latency from adc_data_rd to dac_data_wr SHALL be 2 cycles; peak throughput SHALL be one sample per 3 cycles.
REQ-027 adc_data_rd SHALL never assert while adc_fifo_empty=1 or while the FSM is not in IDLE.
REQ-028 dac_data_wr SHALL never assert while dac_fifo_full=1.
REQ-029 Deasserting enable mid-sample SHALL NOT abort the sample; the sample SHALL complete through WRITE, and no further fetch SHALL occur.
REQ-030 clip_cnt SHALL increment by 1 per sample in CALC when either channel saturates, excluding bypass and mute, and SHALL saturate at all-ones.
REQ-031 When clip_clr coincides with a clip event, clip_clr SHALL win and clip_cnt SHALL become 0.

Reset
REQ-032 While rst=0, the FSM SHALL be IDLE, adc_data_rd=0, dac_data_wr=0, dac_data_in=0, clip_cnt=0 and busy=0.
REQ-033 Reset asserted mid-sample SHALL discard the in-flight sample without issuing dac_data_wr.
REQ-034 The first fetch after reset release SHALL occur no earlier than the first rising edge of clk with rst=1.

Structure
REQ-035 The shared package audio_pkg SHALL hold SAMPLE_W=16, the channel packing offsets, and the FSM state encoding.
REQ-036 Per-channel multiply, shift and saturate SHALL live in one sub-module, audio_gain_sat, instantiated twice; that sub-module SHALL be combinational and SHALL output a clip flag.

Verification
REQ-037 Gain 8'h20/8'h20 with sample 32'h1000_F000 -> dac_data_in=32'h2000_E000, written 2 cycles after adc_data_rd, clip_cnt=0.
REQ-038 gain_l=8'hFF with L=16'h7FFF and R=16'h8000 at gain_r=8'h20 -> output 32'h7FFF_8000, clip_cnt=1.
REQ-039 dac_fifo_full held high for 10 cycles while in WRITE -> no dac_data_wr, no adc_data_rd, data held stable, and the write occurs in the first cycle after full drops.
REQ-040 mute=1 and bypass=1 with sample 32'h1234_5678 -> output 32'h0000_0000, FIFO still popped, clip_cnt unchanged.
REQ-041 8 queued samples, enable dropped after the 3rd adc_data_rd -> exactly 3 dac_data_wr pulses, then busy=0.
REQ-042 rst pulled low during CALC, then released -> no dac_data_wr from the discarded sample, and the next sample is processed normally.
